// File: rtl/toggle_burst_pkg.sv
// toggle_burst_pkg: shared state encoding, default widths and half-period clamp for toggle_burst_ctrl.
package toggle_burst_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int CNT_W_DEF = 8;
  localparam int DIV_W_DEF = 4;
  function automatic logic [31:0] clamp_hp(input logic [31:0] hp);
    return (hp == 32'd0) ? 32'd1 : hp;
  endfunction
endpackage

// File: rtl/toggle_phase_div.sv
// toggle_phase_div: level-duration down-counter; o_tick marks the cycle whose edge ends the current level.
module toggle_phase_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_hp,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_reload;
  assign o_tick = r_phase == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase  <= '0;
      r_reload <= '0;
    end else if (i_load) begin
      r_reload <= i_hp - DIV_W'(1);
      r_phase  <= i_hp - DIV_W'(1);
    end else if (i_en) begin
      r_phase <= o_tick ? r_reload : r_phase - DIV_W'(1);
    end
  end
endmodule

// File: rtl/toggle_burst_ctrl.sv
// toggle_burst_ctrl: burst sequencer driving dout through burst_len level changes of half_period cycles each.
// Define TOGGLE_BURST_CONTINUOUS_EN to make burst_len==0 run indefinitely until abort or rst.
module toggle_burst_ctrl
  import toggle_burst_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             abort,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] toggles_left
);
`ifdef TOGGLE_BURST_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  state_t           r_state;
  logic             r_dout;
  logic [CNT_W-1:0] r_rem;
  logic             w_accept;
  logic             w_run;
  logic             w_tick;
  logic [DIV_W-1:0] w_hp;
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_run    = r_state == RUN;
  assign w_hp     = DIV_W'(clamp_hp(32'(half_period)));
  toggle_phase_div #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_en   (w_run),
    .i_hp   (w_hp),
    .o_tick (w_tick)
  );
  // A continuous burst keeps rem at 0, so the rem==1 exit below never fires for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dout  <= 1'b0;
      r_rem   <= '0;
    end else if (w_accept) begin
      r_state <= (burst_len != '0 || CONT) ? RUN : DONE;
      r_dout  <= 1'b0;
      r_rem   <= burst_len;
    end else if (w_run) begin
      if (abort) begin
        r_state <= IDLE;
        r_dout  <= 1'b0;
        r_rem   <= '0;
      end else if (w_tick) begin
        r_dout <= ~r_dout;
        r_rem  <= r_rem - CNT_W'(r_rem != '0);
        if (r_rem == CNT_W'(1)) r_state <= DONE;
      end
    end else begin
      r_state <= IDLE;
    end
  end
  assign dout         = r_dout;
  assign busy         = w_run;
  assign done         = r_state == DONE;
  assign toggles_left = r_rem;
endmodule

// File: doc/toggle_burst_ctrl.md
Name: toggle_burst_ctrl

Overview:
- Controller that sequences an odd/even toggling output.
- On a start request it drives `dout` through a programmed number of level changes, each level lasting a programmed number of clock cycles.
- Reports busy/done status and the remaining toggle count.
- Serves as the scheduling front-end for the odd/even toggle datapath: hp=1 reproduces plain per-cycle alternation.

Parameters:
- CNT_W, 8: width of burst_len and toggles_left (max burst 2^CNT_W-1 toggles).
- DIV_W, 4: width of half_period (max level duration 2^DIV_W-1 cycles).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset; overrides every other input.
- start  in  1  request a burst; sampled on clk edge; accepted only in IDLE or DONE.
- half_period  in  DIV_W  cycles per output level, sampled with accepted start; 0 treated as 1.
- burst_len  in  CNT_W  number of dout toggles, sampled with accepted start.
- abort  in  1  cancel running burst; effective only in RUN.
- dout  out  1  toggling output.
- busy  out  1  high while in RUN.
- done  out  1  high for exactly the one cycle spent in DONE.
- toggles_left  out  CNT_W  remaining toggles of current burst; 0 outside RUN.

Behaviour:
- States: IDLE, RUN, DONE (2-bit encoding). All outputs are registered or Moore decodes of state; no combinational input-to-output path.
- Reset values: state=IDLE, dout=0, busy=0, done=0, toggles_left=0, phase counter=0.
- IDLE: dout holds its value. start=1 at edge E0 does the following:
  - latch hp = (half_period==0 ? 1 : half_period) and rem = burst_len;
  - force dout=0;
  - set phase = hp-1;
  - go to RUN if burst_len != 0, else go to DONE.
- RUN, each edge:
  - if phase==0: dout flips, rem decrements, phase reloads hp-1;
  - otherwise phase decrements.
  - First toggle occurs at E0+hp; toggle k occurs at E0+k*hp.
  - At the edge producing the last toggle (rem 1->0): go to DONE. The final dout level equals burst_len[0].
- DONE: done=1 and busy=0 for one cycle, then IDLE. start in DONE is accepted exactly as in IDLE (back-to-back bursts; done still pulses that cycle).
- start during RUN: ignored; latched parameters do not change.
- abort during RUN: next edge goes to IDLE with dout=0 and toggles_left=0; no done pulse. abort outside RUN is ignored.
- abort and last toggle on the same edge: abort wins (IDLE, no done, dout=0).
- rst mid-burst: next edge restores all reset values, no done pulse.
- Counters never wrap: rem stops at 0, and phase reloads rather than underflowing.

Optional Feature:
- Macro: TOGGLE_BURST_CONTINUOUS_EN.
- Defined: burst_len==0 at start enters RUN in continuous mode. dout toggles every hp cycles indefinitely, toggles_left stays 0, and only abort or rst exits. No done pulse is ever produced for a continuous burst.
- Undefined: burst_len==0 goes straight to DONE (done pulse at E0+1 cycle, dout=0, no toggles).

Decomposition:
- Package toggle_burst_pkg contains:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default CNT_W/DIV_W constants;
  - helper function clamping half_period 0->1.
- One natural sub-module, toggle_phase_div: the hp down-counter with load/enable inputs that emits a one-cycle tick when phase==0. The top FSM owns dout, rem and status.

Test Plan:
- Reset then idle 10 cycles -> dout=0, busy=0, done=0, toggles_left=0 throughout.
- start with hp=1, burst_len=5 -> dout 0,1,0,1,0,1 on consecutive edges E0..E5; busy high E0..E4; done=1 only in the cycle after E5; final dout=1.
- start with hp=3, burst_len=4 -> toggles at E0+3,+6,+9,+12; toggles_left 4,3,2,1,0; done pulse once; final dout=0.
- start in the DONE cycle of the previous burst (hp=2, burst_len=2) -> new burst accepted with no IDLE gap; dout forced to 0; done pulses for both bursts.
- abort after 2 of 6 toggles (hp=2) -> next edge: IDLE, dout=0, busy=0, no done pulse. A second start during RUN of another burst is ignored.
- half_period=0, burst_len=0 -> without macro: done pulse next cycle and dout stays 0. With TOGGLE_BURST_CONTINUOUS_EN: dout toggles every cycle for 50 cycles until abort, and done is never asserted.
